uart_core_fifo: RTL and testbench
=================================

// Module: uart_core_fifo
// PURPOSE
//  Parametrised full-duplex UART core; successor to the fixed 8N1 rx/tx pair.
//  - Adds configurable data width, stop bits, 16x-oversampled RX and an RX FIFO.
//  - Adds framing/overrun reporting and optional parity.
//  - Sits between the host-side command logic and the board UART pins.
// PARAMETERS
//  BAUD_RATE   24'd9600        line rate in bit/s
//  CLOCK_FREQ  28'd100000000   clk_int frequency in Hz
//  OVERSAMPLE  16              ticks per bit, even, >=8
//  DATA_BITS   8               payload bits per frame, 5..8
//  STOP_BITS   1               stop bits, 1 or 2 (RX checks first only)
//  FIFO_DEPTH  4               RX FIFO entries, power of 2, >=2
//  PARITY_ODD  0               0 = even, 1 = odd (used only with UART_PARITY_EN)
// PORTS
//  clk_int             in   1            single system clock
//  uart_reset          in   1            synchronous, active-high reset
//  uart_transmit_data  in   DATA_BITS    TX payload, LSB sent first
//  uart_tx_start       in   1            TX request; accepted when uart_tx_ready=1
//  uart_tx_ready       out  1            TX idle, can accept a frame
//  uart_tx_d_out       out  1            serial TX line, idle high
//  uart_rx_d_in        in   1            serial RX line, asynchronous
//  uart_received_data  out  DATA_BITS    FIFO head payload (show-ahead)
//  uart_rx_valid       out  1            FIFO not empty
//  uart_rx_pop         in   1            consume head when uart_rx_valid=1
//  uart_rx_frame_err   out  1            head entry had stop bit sampled 0
//  uart_rx_parity_err  out  1            head entry parity mismatch (0 if parity off)
//  uart_rx_overrun     out  1            1-cycle pulse: frame dropped, FIFO full
//  uart_rx_count       out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset values
//   - uart_tx_d_out=1, uart_tx_ready=1, uart_rx_valid=0.
//   - uart_rx_count=0; uart_rx_overrun=0; error outputs 0.
//   - Both FSMs go to IDLE; divider and FIFO pointers clear.
//   - Reset mid-frame aborts the frame; the line goes high on the next edge.
//  Tick generation
//   - Free-running divider DIV=CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE), truncated, min 1.
//   - One tick = 1 clk pulse every DIV clocks; shared by TX and RX.
//  TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE
//   - Each state holds for OVERSAMPLE ticks per bit; STOP holds STOP_BITS bits.
//   - Accept = uart_tx_start & uart_tx_ready: latch data; ready=0 on the next edge.
//   - The line goes low at the first tick after accept.
//   - uart_tx_start while busy is ignored.
//   - Ready returns 1 on the edge after the final stop bit completes.
//   - No start latched in that same cycle.
//  RX input and FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE
//   - 2-flop synchroniser on uart_rx_d_in.
//   - IDLE: sync line 0 at a tick -> START.
//   - START: after OVERSAMPLE/2 ticks, resample; if 1 the start is false -> IDLE.
//   - Every bit is sampled once at mid-bit (OVERSAMPLE ticks after the previous sample).
//   - At the first stop-bit sample, push {data, frame_err, parity_err} to the FIFO.
//   - Stop sample 1 -> IDLE.
//   - Stop sample 0 (break) -> frame_err set; stay in STOP until sync line is 1, then IDLE.
//  FIFO
//   - Show-ahead; head flags are valid with the data.
//   - Pop with valid=0 is ignored.
//   - Push on full: frame dropped, FIFO unchanged, uart_rx_overrun pulses 1 cycle.
//   - Push and pop in the same cycle, including when full: both occur, count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
// CONFIGURATION
//  UART_PARITY_EN defined
//   - One parity bit is inserted after the data bits.
//   - TX value = XOR(data)^PARITY_ODD.
//   - RX checks it; mismatch sets parity_err in the entry.
//  UART_PARITY_EN undefined
//   - No parity bit; uart_rx_parity_err tied to 0; PARITY_ODD unused.
// TESTING (CLOCK_FREQ=1600000, BAUD_RATE=100000, OVERSAMPLE=16 -> DIV=1, 16 clk/bit)
//  1 TX 8N1
//   - Start with data 8'hA5.
//   - Line is low 16 clk, then bits 1,0,1,0,0,1,0,1 at 16 clk each, then high 16 clk.
//   - Ready is 0 for 160 clk.
//  2 TX busy
//   - Second start 20 clk after the first.
//   - Ignored; exactly one frame on the line.
//  3 RX loopback
//   - Tie TX to RX and send 8'h3C, 8'hC3.
//   - count=2; data 3C then C3 on pops; no error flags.
//  4 Glitch and break
//   - 4-clk low pulse -> no push.
//   - Frame 8'h55 with stop=0 -> entry 55 with frame_err=1.
//   - No further frame until the line returns high.
//  5 Overrun
//   - Receive 5 frames with FIFO_DEPTH=4 and no pop.
//   - One overrun pulse; count=4; first 4 bytes retained in order.
//  6 UART_PARITY_EN, PARITY_ODD=0
//   - TX 8'h07 -> parity bit 1.
//   - RX with parity bit flipped -> parity_err=1 on that entry.
//   - Reset mid-frame -> line high next clk, ready=1, count=0.

Source files
------------

// File: rtl/uart_core_fifo.sv
// uart_core_fifo: oversampled full-duplex UART with show-ahead RX FIFO; parity bit enabled by UART_PARITY_EN
module uart_core_fifo #(
    parameter logic [23:0] BAUD_RATE  = 24'd9600,
    parameter logic [27:0] CLOCK_FREQ = 28'd100000000,
    parameter int          OVERSAMPLE = 16,
    parameter int          DATA_BITS  = 8,
    parameter int          STOP_BITS  = 1,
    parameter int          FIFO_DEPTH = 4,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                          clk_int,
    input  logic                          uart_reset,
    input  logic [DATA_BITS-1:0]          uart_transmit_data,
    input  logic                          uart_tx_start,
    output logic                          uart_tx_ready,
    output logic                          uart_tx_d_out,
    input  logic                          uart_rx_d_in,
    output logic [DATA_BITS-1:0]          uart_received_data,
    output logic                          uart_rx_valid,
    input  logic                          uart_rx_pop,
    output logic                          uart_rx_frame_err,
    output logic                          uart_rx_parity_err,
    output logic                          uart_rx_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   uart_rx_count
);
    localparam int DIV_RAW = int'(CLOCK_FREQ) / (int'(BAUD_RATE) * OVERSAMPLE);
    localparam int DIV = DIV_RAW < 1 ? 1 : DIV_RAW;
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;
`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

    logic [DW-1:0] div_cnt;
    logic          tick;

    assign tick = div_cnt == DW'(DIV - 1);

    always_ff @(posedge clk_int) begin
        if (uart_reset) div_cnt <= '0;
        else div_cnt <= tick ? '0 : div_cnt + DW'(1);
    end

    state_t                tx_state, tx_state_n;
    logic [TW-1:0]         tx_tcnt;
    logic [3:0]            tx_bcnt;
    logic [DATA_BITS-1:0]  tx_shift;
    logic                  tx_par;
    logic                  tx_end;

    assign tx_end = tick && tx_tcnt == TW'(OVERSAMPLE - 1);

    // ARM holds the line high until the divider's next tick so the start bit is a full bit long
    always_comb begin
        tx_state_n = tx_state;
        case (tx_state)
            S_IDLE:  if (uart_tx_start) tx_state_n = tick ? S_START : S_ARM;
            S_ARM:   if (tick) tx_state_n = S_START;
            S_START: if (tx_end) tx_state_n = S_DATA;
            S_DATA:  if (tx_end && tx_bcnt == 4'(DATA_BITS - 1)) tx_state_n = PAR_EN ? S_PAR : S_STOP;
            S_PAR:   if (tx_end) tx_state_n = S_STOP;
            S_STOP:  if (tx_end && tx_bcnt == 4'(STOP_BITS - 1)) tx_state_n = S_IDLE;
            default: tx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_int) begin
        if (uart_reset) begin
            tx_state <= S_IDLE;
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            if (tx_state_n != tx_state) begin
                tx_tcnt <= '0;
                tx_bcnt <= '0;
            end else if (tick) begin
                tx_tcnt <= tx_end ? '0 : tx_tcnt + TW'(1);
                if (tx_end) begin
                    tx_bcnt  <= tx_bcnt + 4'd1;
                    tx_shift <= tx_shift >> 1;
                end
            end
            if (tx_state == S_IDLE && uart_tx_start) begin
                tx_shift <= uart_transmit_data;
                tx_par   <= ^uart_transmit_data ^ PARITY_ODD;
            end
        end
    end

    assign uart_tx_ready = tx_state == S_IDLE;
    assign uart_tx_d_out = tx_state == S_START ? 1'b0 :
                           tx_state == S_DATA  ? tx_shift[0] :
                           tx_state == S_PAR   ? tx_par : 1'b1;

    logic [1:0]            rx_sync;
    logic                  rx_s;
    state_t                rx_state, rx_state_n;
    logic [TW-1:0]         rx_tcnt;
    logic [3:0]            rx_bcnt;
    logic [DATA_BITS-1:0]  rx_shift;
    logic                  rx_perr;
    logic                  rx_end;
    logic                  rx_push;

    assign rx_s    = rx_sync[1];
    assign rx_end  = tick && rx_tcnt == (rx_state == S_START ? TW'(OVERSAMPLE / 2 - 1) : TW'(OVERSAMPLE - 1));
    assign rx_push = rx_state == S_STOP && rx_end;

    always_comb begin
        rx_state_n = rx_state;
        case (rx_state)
            S_IDLE:  if (tick && !rx_s) rx_state_n = S_START;
            S_START: if (rx_end) rx_state_n = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (rx_end && rx_bcnt == 4'(DATA_BITS - 1)) rx_state_n = PAR_EN ? S_PAR : S_STOP;
            S_PAR:   if (rx_end) rx_state_n = S_STOP;
            S_STOP:  if (rx_end) rx_state_n = rx_s ? S_IDLE : S_BRK;
            S_BRK:   if (rx_s) rx_state_n = S_IDLE;
            default: rx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_int) begin
        if (uart_reset) begin
            rx_sync  <= 2'b11;
            rx_state <= S_IDLE;
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_shift <= '0;
            rx_perr  <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], uart_rx_d_in};
            rx_state <= rx_state_n;
            if (rx_state_n != rx_state) begin
                rx_tcnt <= '0;
                rx_bcnt <= '0;
            end else if (tick) begin
                rx_tcnt <= rx_end ? '0 : rx_tcnt + TW'(1);
                if (rx_end) rx_bcnt <= rx_bcnt + 4'd1;
            end
            if (rx_end && rx_state == S_DATA) rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            if (rx_end && rx_state == S_PAR) rx_perr <= rx_s ^ (^rx_shift) ^ PARITY_ODD;
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, wr;
    logic [EW-1:0] head;

    assign full = count == (AW + 1)'(FIFO_DEPTH);
    assign pop  = uart_rx_pop && uart_rx_valid;
    assign wr   = rx_push && (!full || pop);
    assign head = mem[rd_ptr];

    always_ff @(posedge clk_int) begin
        if (wr) mem[wr_ptr] <= {rx_shift, !rx_s, rx_perr};
    end

    always_ff @(posedge clk_int) begin
        if (uart_reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            uart_rx_overrun <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count           <= count + (AW + 1)'(wr) - (AW + 1)'(pop);
            uart_rx_overrun <= rx_push && full && !pop;
        end
    end

    assign uart_rx_valid      = count != '0;
    assign uart_rx_count      = count;
    assign uart_received_data = head[EW-1:2];
    assign uart_rx_frame_err  = uart_rx_valid & head[1];
    assign uart_rx_parity_err = PAR_EN & uart_rx_valid & head[0];
endmodule

// File: tb/tb_uart_core_fifo.sv
// tb_uart_core_fifo: randomized directed bench for uart_core_fifo at 16 clk per bit
module tb_uart_core_fifo;
    logic clk_int = 1'b0;
    always #5 clk_int = ~clk_int;

    logic       rst, tx_start, ready, tx_out, rx_in, valid, pop, ferr, perr, ovr;
    logic       loop, drv;
    logic [7:0] tx_data, rx_data;
    logic [2:0] count;

    assign rx_in = loop ? tx_out : drv;

`ifdef UART_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    uart_core_fifo #(
        .BAUD_RATE(24'd100000), .CLOCK_FREQ(28'd1600000), .OVERSAMPLE(16),
        .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(1'b0)
    ) dut (
        .clk_int(clk_int), .uart_reset(rst),
        .uart_transmit_data(tx_data), .uart_tx_start(tx_start), .uart_tx_ready(ready), .uart_tx_d_out(tx_out),
        .uart_rx_d_in(rx_in), .uart_received_data(rx_data), .uart_rx_valid(valid), .uart_rx_pop(pop),
        .uart_rx_frame_err(ferr), .uart_rx_parity_err(perr), .uart_rx_overrun(ovr), .uart_rx_count(count)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } ent_t;

    ent_t q[$];
    int   tests = 0, fails = 0, exp_ovr = 0, ovr_cnt = 0, base;

    always @(posedge clk_int) if (ovr) ovr_cnt <= ovr_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic [7:0] d, input logic fe, input logic pe);
        ent_t e;
        e.d = d;
        e.fe = fe;
        e.pe = pe;
        if (q.size() < 4) q.push_back(e);
        else exp_ovr++;
    endtask

    task automatic tx_frame(input logic [7:0] d, input int busy_at);
        logic b[$];
        b.push_back(1'b0);
        for (int k = 0; k < 8; k++) b.push_back(d[k]);
        if (PAR) b.push_back(^d);
        b.push_back(1'b1);
        @(negedge clk_int);
        tx_data = d;
        tx_start = 1'b1;
        @(posedge clk_int); #1;
        tx_start = 1'b0;
        for (int i = 0; i < b.size() * 16; i++) begin
            chk("tx_line", tx_out, b[i / 16]);
            chk("tx_ready_busy", ready, 0);
            tx_start = i == busy_at;
            if (i == busy_at) tx_data = ~d;
            @(posedge clk_int); #1;
        end
        tx_start = 1'b0;
        chk("tx_ready_back", ready, 1);
        repeat (20) begin
            chk("tx_idle_line", tx_out, 1);
            @(posedge clk_int); #1;
        end
        if (loop) model_push(d, 1'b0, 1'b0);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_v, input logic flip);
        logic b[$];
        b.push_back(1'b0);
        for (int k = 0; k < 8; k++) b.push_back(d[k]);
        if (PAR) b.push_back(^d ^ flip);
        b.push_back(stop_v);
        @(negedge clk_int);
        for (int k = 0; k < b.size(); k++) begin
            drv = b[k];
            repeat (16) @(negedge clk_int);
        end
        repeat (8) @(negedge clk_int);
        model_push(d, !stop_v, PAR & flip);
    endtask

    task automatic pop_check();
        ent_t e;
        e = q.pop_front();
        @(negedge clk_int);
        chk("rx_valid", valid, 1);
        chk("rx_data", rx_data, e.d);
        chk("rx_frame_err", ferr, e.fe);
        chk("rx_parity_err", perr, e.pe);
        pop = 1'b1;
        @(posedge clk_int); #1;
        pop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00; pop = 1'b0; loop = 1'b0; drv = 1'b1;
        repeat (3) @(posedge clk_int); #1;
        chk("rst_tx_line", tx_out, 1);
        chk("rst_ready", ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_count", count, 0);
        chk("rst_overrun", ovr, 0);
        chk("rst_frame_err", ferr, 0);
        chk("rst_parity_err", perr, 0);
        @(negedge clk_int) rst = 1'b0;

        tx_frame(8'hA5, -1);
        tx_frame(8'($urandom_range(255)), 20);
        repeat (3) tx_frame(8'($urandom_range(255)), int'($urandom_range(150)));

        loop = 1'b1;
        tx_frame(8'h3C, -1);
        tx_frame(8'hC3, -1);
        chk("loop_count", count, q.size());
        pop_check();
        pop_check();
        chk("loop_empty", valid, 0);
        repeat (3) begin
            tx_frame(8'($urandom_range(255)), -1);
            chk("loop_rand_count", count, q.size());
            pop_check();
        end
        loop = 1'b0;

        @(negedge clk_int) drv = 1'b0;
        repeat (4) @(negedge clk_int);
        drv = 1'b1;
        repeat (40) @(negedge clk_int);
        chk("glitch_count", count, 0);

        drive_frame(8'h55, 1'b0, 1'b0);
        repeat (200) @(negedge clk_int);
        chk("break_count", count, q.size());
        pop_check();
        repeat (40) @(negedge clk_int);
        chk("break_hold_count", count, 0);
        drv = 1'b1;
        repeat (20) @(negedge clk_int);
        drive_frame(8'($urandom_range(255)), 1'b1, 1'b0);
        chk("after_break_count", count, q.size());
        pop_check();

        base = ovr_cnt;
        exp_ovr = 0;
        repeat (5) drive_frame(8'($urandom_range(255)), 1'b1, 1'b0);
        chk("overrun_pulses", ovr_cnt - base, exp_ovr);
        chk("overrun_count", count, q.size());
        repeat (4) pop_check();
        chk("overrun_drained", valid, 0);

`ifdef UART_PARITY_EN
        tx_frame(8'h07, -1);
        drive_frame(8'($urandom_range(255)), 1'b1, 1'b1);
        drive_frame(8'($urandom_range(255)), 1'b1, 1'b0);
        chk("parity_count", count, q.size());
        pop_check();
        pop_check();
`endif

        drive_frame(8'($urandom_range(255)), 1'b1, 1'b0);
        chk("pre_reset_count", count, q.size());
        loop = 1'b1;
        @(negedge clk_int);
        tx_data = 8'($urandom_range(255));
        tx_start = 1'b1;
        @(posedge clk_int); #1;
        tx_start = 1'b0;
        repeat (50) @(posedge clk_int);
        @(negedge clk_int) rst = 1'b1;
        @(posedge clk_int); #1;
        chk("midrst_tx_line", tx_out, 1);
        chk("midrst_ready", ready, 1);
        chk("midrst_count", count, 0);
        chk("midrst_valid", valid, 0);
        q.delete();
        @(negedge clk_int);
        rst = 1'b0;
        loop = 1'b0;
        tx_frame(8'($urandom_range(255)), -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
